// File: rtl/lfsr_prbs_chk_if.sv
// Stream and status bundle between a PRBS sample source and lfsr_prbs_chk.
// The master drives the sampled bit stream and controls; the slave is the checker.
interface lfsr_prbs_chk_if #(
    parameter int CNT_WIDTH = 32,
    parameter int ERR_WIDTH = 16
);
    logic                 enable;
    logic                 clear;
    logic                 sample_valid;
    logic                 sample_in;
    logic                 locked;
    logic                 err_pulse;
    logic [CNT_WIDTH-1:0] bit_count;
    logic [ERR_WIDTH-1:0] err_count;

    modport master (
        output enable, clear, sample_valid, sample_in,
        input  locked, err_pulse, bit_count, err_count
    );

    modport slave (
        input  enable, clear, sample_valid, sample_in,
        output locked, err_pulse, bit_count, err_count
    );
endinterface

// File: rtl/lfsr_prbs_chk.sv
// Self-synchronising serial PRBS checker: seeds from the received stream, hunts for
// a run of correct predictions, then free-runs its own LFSR and counts bit errors.
module lfsr_prbs_chk #(
    parameter int                    LFSR_WIDTH   = 8,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY    = 8'hBE,
    parameter int                    LOCK_COUNT   = 16,
    parameter int                    UNLOCK_COUNT = 4,
    parameter int                    CNT_WIDTH    = 32,
    parameter int                    ERR_WIDTH    = 16
) (
    input  logic           clk,
    input  logic           reset,
    lfsr_prbs_chk_if.slave bus
);
    localparam int W  = LFSR_WIDTH;
    localparam int SW = $clog2(W);
    localparam int GW = $clog2(LOCK_COUNT) + 1;
    localparam int UW = (UNLOCK_COUNT > 1) ? $clog2(UNLOCK_COUNT) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SEED   = 2'd1;
    localparam logic [1:0] S_HUNT   = 2'd2;
    localparam logic [1:0] S_LOCKED = 2'd3;

    logic [1:0]           state, state_n;
    logic [W-1:0]         h, h_n;
    logic [SW-1:0]        seed_cnt, seed_n;
    logic [GW-1:0]        good_run, good_n;
    logic [UW-1:0]        bad_run, bad_n;
    logic                 locked_q, err_pulse_q;
    logic [CNT_WIDTH-1:0] bit_count_q;
    logic [ERR_WIDTH-1:0] err_count_q;
    logic                 p, bit_ok, chk_bit, err_bit;

    assign p      = ^(h & LFSR_POLY);
    assign bit_ok = (bus.sample_in == p);

    always_comb begin
        state_n = state;
        h_n     = h;
        seed_n  = seed_cnt;
        good_n  = good_run;
        bad_n   = bad_run;
        chk_bit = 1'b0;
        err_bit = 1'b0;
        if (!bus.enable) begin
            state_n = S_IDLE;
            h_n     = '0;
            seed_n  = '0;
            good_n  = '0;
            bad_n   = '0;
        end else begin
            case (state)
                S_IDLE: state_n = S_SEED;
                S_SEED: if (bus.sample_valid) begin
                    h_n = {h[W-2:0], bus.sample_in};
                    if (seed_cnt == SW'(W - 1)) begin
                        seed_n  = '0;
                        state_n = S_HUNT;
                    end else begin
                        seed_n = seed_cnt + 1'b1;
                    end
                end
                S_HUNT: if (bus.sample_valid) begin
                    h_n = {h[W-2:0], bus.sample_in};
                    // an all-zero history predicts 0 forever, so it must never count as good
                    if (bit_ok && h != '0) begin
                        if (good_run == GW'(LOCK_COUNT - 1)) begin
                            good_n  = '0;
                            state_n = S_LOCKED;
                        end else begin
                            good_n = good_run + 1'b1;
                        end
                    end else begin
                        good_n = '0;
                    end
                end
                S_LOCKED: if (bus.sample_valid) begin
                    // free-run on the prediction so a single flipped bit costs one error only
                    h_n     = {h[W-2:0], p};
                    chk_bit = 1'b1;
                    if (!bit_ok) begin
                        err_bit = 1'b1;
                        if (UNLOCK_COUNT != 0 && bad_run == UW'(UNLOCK_COUNT - 1)) begin
                            state_n = S_SEED;
                            h_n     = '0;
                            good_n  = '0;
                            bad_n   = '0;
                        end else if (UNLOCK_COUNT != 0) begin
                            bad_n = bad_run + 1'b1;
                        end
                    end else begin
                        bad_n = '0;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            h           <= '0;
            seed_cnt    <= '0;
            good_run    <= '0;
            bad_run     <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            bit_count_q <= '0;
            err_count_q <= '0;
        end else begin
            state       <= state_n;
            h           <= h_n;
            seed_cnt    <= seed_n;
            good_run    <= good_n;
            bad_run     <= bad_n;
            locked_q    <= (state_n == S_LOCKED);
            err_pulse_q <= err_bit;
            if (bus.clear)
                bit_count_q <= '0;
            else if (chk_bit && bit_count_q != '1)
                bit_count_q <= bit_count_q + 1'b1;
            if (bus.clear)
                err_count_q <= '0;
            else if (err_bit && err_count_q != '1)
                err_count_q <= err_count_q + 1'b1;
        end
    end

    assign bus.locked    = locked_q;
    assign bus.err_pulse = err_pulse_q;
    assign bus.bit_count = bit_count_q;
    assign bus.err_count = err_count_q;
endmodule

// File: tb/tb_lfsr_prbs_chk.sv
// Bench for lfsr_prbs_chk: a behavioural PRBS generator feeds two checker builds
// (defaults, and a 4-bit error counter with auto-unlock off); expectations are scenario arithmetic.
module tb_lfsr_prbs_chk;
    localparam int         W    = 8;
    localparam logic [7:0] POLY = 8'hBE;
    localparam int         LOCK_BITS = W + 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic clear = 1'b0;
    logic sample_valid = 1'b0;
    logic sample_in = 1'b0;

    int checks = 0;
    int failures = 0;
    int pulses_a = 0;
    int pulses_b = 0;
    logic [7:0] gs;

    lfsr_prbs_chk_if #(.CNT_WIDTH(32), .ERR_WIDTH(16)) bus_a ();
    lfsr_prbs_chk_if #(.CNT_WIDTH(32), .ERR_WIDTH(4))  bus_b ();

    assign bus_a.enable       = enable;
    assign bus_a.clear        = clear;
    assign bus_a.sample_valid = sample_valid;
    assign bus_a.sample_in    = sample_in;
    assign bus_b.enable       = enable;
    assign bus_b.clear        = clear;
    assign bus_b.sample_valid = sample_valid;
    assign bus_b.sample_in    = sample_in;

    lfsr_prbs_chk #(.UNLOCK_COUNT(4)) dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
    lfsr_prbs_chk #(.ERR_WIDTH(4), .UNLOCK_COUNT(0)) dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint unsigned obs, input longint unsigned exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // reference generator: emitted bit is the feedback bit
    task automatic gen_next(output logic b);
        logic fb;
        fb = ^(gs & POLY);
        gs = {gs[6:0], fb};
        b  = fb;
    endtask

    // one clock: drive at negedge, step through posedge, land on next negedge
    task automatic cyc(input logic v, input logic b, input logic clr);
        sample_valid = v;
        sample_in    = b;
        clear        = clr;
        @(posedge clk);
        @(negedge clk);
        pulses_a += int'(bus_a.err_pulse);
        pulses_b += int'(bus_b.err_pulse);
        sample_valid = 1'b0;
        clear        = 1'b0;
    endtask

    task automatic send(input logic flip, input logic clr);
        logic b;
        gen_next(b);
        cyc(1'b1, b ^ flip, clr);
    endtask

    task automatic restart(input logic [7:0] seed);
        reset  = 1'b1;
        enable = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        reset  = 1'b0;
        gs     = seed;
        enable = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        pulses_a = 0;
        pulses_b = 0;
    endtask

    task automatic lock_up(input bit gaps, input string tag);
        for (int k = 1; k <= LOCK_BITS; k++) begin
            if (gaps) begin
                int g = $urandom_range(0, 2);
                for (int j = 0; j < g; j++) cyc(1'b0, 1'b0, 1'b0);
            end
            send(1'b0, 1'b0);
            check(tag, bus_a.locked, (k == LOCK_BITS) ? 1 : 0);
        end
    endtask

    initial begin
        bit   saw_lock;
        logic prev_flip;
        int   ne, nb;
        @(negedge clk);

        // reset state
        cyc(1'b0, 1'b0, 1'b0);
        check("rst_locked", bus_a.locked, 0);
        check("rst_pulse", bus_a.err_pulse, 0);
        check("rst_bits", bus_a.bit_count, 0);
        check("rst_errs", bus_a.err_count, 0);

        // clean lock, seed EF, one bit per cycle
        restart(8'hEF);
        lock_up(1'b0, "clean_lock");
        for (int i = 0; i < 100; i++) send(1'b0, 1'b0);
        check("clean_bits", bus_a.bit_count, 100);
        check("clean_errs", bus_a.err_count, 0);
        check("clean_pulses", pulses_a, 0);

        // single flipped bit
        restart(8'hEF);
        lock_up(1'b0, "single_lock");
        for (int i = 1; i <= 100; i++) begin
            send(i == 50, 1'b0);
            check("single_pulse", bus_a.err_pulse, (i == 50) ? 1 : 0);
        end
        check("single_errs", bus_a.err_count, 1);
        check("single_locked", bus_a.locked, 1);
        check("single_bits", bus_a.bit_count, 100);
        check("single_npulse", pulses_a, 1);

        // stuck-at input never locks
        restart(8'h01);
        saw_lock = 1'b0;
        for (int i = 0; i < 400; i++) begin
            cyc(1'b1, (i >= 200), 1'b0);
            if (bus_a.locked || bus_b.locked) saw_lock = 1'b1;
        end
        check("stuck_lock", saw_lock, 0);
        check("stuck_bits", bus_a.bit_count, 0);
        check("stuck_errs", bus_a.err_count, 0);

        // unlock after 4 consecutive errors, then relock
        restart(8'($urandom_range(1, 255)));
        lock_up(1'b0, "unl_lock");
        for (int i = 0; i < 30; i++) send(1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            send(1'b1, 1'b0);
            check("unl_locked", bus_a.locked, (i < 4) ? 1 : 0);
        end
        check("unl_errs", bus_a.err_count, 4);
        check("unl_bits", bus_a.bit_count, 34);
        lock_up(1'b0, "relock");
        check("relock_bits_held", bus_a.bit_count, 34);
        for (int i = 0; i < 10; i++) send(1'b0, 1'b0);
        check("relock_bits", bus_a.bit_count, 44);
        check("relock_errs", bus_a.err_count, 4);

        // saturation on the 4-bit counter, then clear against an errored bit
        restart(8'($urandom_range(1, 255)));
        lock_up(1'b0, "sat_lock");
        check("sat_lock_b", bus_b.locked, 1);
        pulses_b = 0;
        for (int i = 0; i < 20; i++) begin
            send(1'b1, 1'b0);
            check("sat_locked_b", bus_b.locked, 1);
        end
        check("sat_pulses", pulses_b, 20);
        check("sat_errs", bus_b.err_count, 15);
        check("sat_bits", bus_b.bit_count, 20);
        send(1'b1, 1'b1);
        check("clr_errs", bus_b.err_count, 0);
        check("clr_bits", bus_b.bit_count, 0);
        check("clr_pulse", bus_b.err_pulse, 1);
        check("clr_locked", bus_b.locked, 1);
        send(1'b0, 1'b0);
        check("post_clr_bits", bus_b.bit_count, 1);

        // random seed, random gaps, sparse random errors
        restart(8'($urandom_range(1, 255)));
        lock_up(1'b1, "gap_lock");
        ne = 0;
        nb = 0;
        prev_flip = 1'b0;
        for (int i = 0; i < 200; i++) begin
            logic flip;
            if ($urandom_range(0, 2) == 0) begin
                cyc(1'b0, 1'b0, 1'b0);
                check("gap_hold_bits", bus_a.bit_count, nb);
                check("gap_hold_pulse", bus_a.err_pulse, 0);
            end
            flip = !prev_flip && ($urandom_range(0, 7) == 0);
            prev_flip = flip;
            ne += int'(flip);
            nb++;
            send(flip, 1'b0);
            check("rnd_pulse", bus_a.err_pulse, flip);
        end
        check("rnd_errs", bus_a.err_count, ne);
        check("rnd_bits", bus_a.bit_count, nb);
        check("rnd_locked", bus_a.locked, 1);

        // enable low drops lock but keeps counts
        enable = 1'b0;
        cyc(1'b1, 1'b0, 1'b0);
        check("dis_locked", bus_a.locked, 0);
        check("dis_bits", bus_a.bit_count, nb);
        check("dis_errs", bus_a.err_count, ne);
        enable = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        lock_up(1'b1, "reen_lock");
        check("reen_bits", bus_a.bit_count, nb);

        // reset while locked
        send(1'b1, 1'b0);
        reset = 1'b1;
        clear = 1'b0;
        cyc(1'b1, 1'b1, 1'b0);
        reset = 1'b0;
        check("mid_rst_locked", bus_a.locked, 0);
        check("mid_rst_pulse", bus_a.err_pulse, 0);
        check("mid_rst_bits", bus_a.bit_count, 0);
        check("mid_rst_errs", bus_a.err_count, 0);
        cyc(1'b0, 1'b0, 1'b0);
        check("post_rst_locked", bus_a.locked, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
